// File: rtl/ram_responder.sv
// Word-addressed RAM slave with a fixed LAT-cycle handshake: BUSY for LAT cycles, then ACCESS for one cycle.
// The controller holds REN/WEN until ACCESS; any drop or change of a request aborts and restarts it.
module ram_responder #(
  parameter int LAT = 2,
  parameter int AW  = 10
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [3:0] LAT4      = 4'(LAT);
  localparam int         DEPTH     = 1 << AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ACC   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d, cnt_cur;
  logic            req_wr_q;
  logic [AW-1:0]   req_idx_q;
  logic [31:0]     load_q;
  logic [31:0]     mem [0:DEPTH-1];

  logic [AW-1:0]   idx;
  logic            hi_bad;
  logic            req_idle, req_err, req_vld;
  logic            is_new, do_acc, rd_acc, wr_acc;

  assign idx = ramaddr[AW+1:2];

  // Address bits above the array are only checkable when the array is narrower than 32-bit space.
  generate
    if (AW < 30) begin : g_hi
      assign hi_bad = |ramaddr[31:AW+2];
    end else begin : g_nohi
      assign hi_bad = 1'b0;
    end
  endgenerate

  assign req_idle = !ramREN && !ramWEN;
  assign req_err  = !req_idle && ((ramREN && ramWEN) || (ramaddr[1:0] != 2'b00) || hi_bad);
  assign req_vld  = !req_idle && !req_err;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cnt_cur  = cnt_q;
    is_new   = 1'b0;
    do_acc   = 1'b0;
    ramstate = RS_FREE;
    if (req_idle) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else if (req_err) begin
      ramstate = RS_ERROR;
      state_d  = IDLE;
      cnt_d    = 4'd0;
    end else begin
      // Anything but an unchanged request already counting starts over from zero.
      is_new  = (state_q != COUNT) || (req_wr_q != ramWEN) || (req_idx_q != idx);
      cnt_cur = is_new ? 4'd0 : cnt_q;
      if (cnt_cur == LAT4) begin
        ramstate = RS_ACCESS;
        do_acc   = 1'b1;
        state_d  = ACC;
        cnt_d    = 4'd0;
      end else begin
        ramstate = RS_BUSY;
        state_d  = COUNT;
        cnt_d    = cnt_cur + 4'd1;
      end
    end
  end

  assign rd_acc  = do_acc && !ramWEN;
  assign wr_acc  = do_acc && ramWEN;
  assign ramload = rd_acc ? mem[idx] : load_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      req_wr_q  <= 1'b0;
      req_idx_q <= '0;
      load_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (req_vld) begin
        req_wr_q  <= ramWEN;
        req_idx_q <= idx;
      end
      if (rd_acc) begin
        load_q <= mem[idx];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (wr_acc) begin
      mem[idx] <= ramstore;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder at LAT=2, AW=10 with hand-computed ramstate/ramload expectations.
module tb_ram_responder;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  int n_chk = 0;
  int n_err = 0;

  ram_responder #(.LAT(2), .AW(10)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One cycle of stimulus: drive on the falling edge, settle, caller samples.
  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    ramREN   = r;
    ramWEN   = w;
    ramaddr  = a;
    ramstore = d;
    #1;
  endtask

  // Full LAT=2 transaction: BUSY, BUSY, ACCESS, then an idle cycle showing FREE.
  task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic chk_load, input logic [31:0] exp_load);
    for (int i = 0; i < 3; i++) begin
      drive(!w, w, a, d);
      chk($sformatf("%s_st%0d", tag, i), {30'd0, ramstate}, (i < 2) ? {30'd0, BUSY} : {30'd0, ACCESS});
      if (i == 2 && chk_load) chk({tag, "_load"}, ramload, exp_load);
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk({tag, "_free"}, {30'd0, ramstate}, {30'd0, FREE});
  endtask

  initial begin
    nRST = 1'b0; ramREN = 1'b0; ramWEN = 1'b0; ramaddr = 32'd0; ramstore = 32'd0;
    #1;
    chk("rst_state", {30'd0, ramstate}, {30'd0, FREE});
    chk("rst_load", ramload, 32'd0);
    drive(1'b1, 1'b0, 32'h40, 32'd0);
    chk("rst_busy", {30'd0, ramstate}, {30'd0, BUSY});
    drive(1'b1, 1'b0, 32'h40, 32'd0);
    chk("rst_noacc", {30'd0, ramstate}, {30'd0, BUSY});
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    nRST = 1'b1;

    // Write/read round trip
    txn("wr40", 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 32'd0);
    txn("rd40", 1'b0, 32'h40, 32'd0, 1'b1, 32'hDEADBEEF);
    chk("hold40", ramload, 32'hDEADBEEF);

    // Error classes never touch memory
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF);
      chk($sformatf("both_err%0d", i), {30'd0, ramstate}, {30'd0, ERROR});
    end
    drive(1'b1, 1'b0, 32'h11, 32'd0);
    chk("misalign_err", {30'd0, ramstate}, {30'd0, ERROR});
    drive(1'b0, 1'b1, 32'h1000, 32'h1);
    chk("range_err", {30'd0, ramstate}, {30'd0, ERROR});
    drive(1'b1, 1'b0, 32'h10, 32'd0);
    chk("err_hold_busy", ramload, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 32'h10, 32'd0);
    drive(1'b1, 1'b0, 32'h10, 32'd0);
    chk("rd10_acc", {30'd0, ramstate}, {30'd0, ACCESS});
    chk("rd10_load", ramload, 32'd0);

    // Address change mid-BUSY restarts counting
    txn("wr20", 1'b1, 32'h20, 32'h11112222, 1'b0, 32'd0);
    txn("wr24", 1'b1, 32'h24, 32'hCAFEF00D, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'h20, 32'd0);
    chk("chg_c0", {30'd0, ramstate}, {30'd0, BUSY});
    drive(1'b1, 1'b0, 32'h24, 32'd0);
    chk("chg_c1", {30'd0, ramstate}, {30'd0, BUSY});
    drive(1'b1, 1'b0, 32'h24, 32'd0);
    chk("chg_c2", {30'd0, ramstate}, {30'd0, BUSY});
    drive(1'b1, 1'b0, 32'h24, 32'd0);
    chk("chg_c3", {30'd0, ramstate}, {30'd0, ACCESS});
    chk("chg_load", ramload, 32'hCAFEF00D);

    // Dropped write has no effect
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b1, 32'h08, 32'h55);
    chk("drop_busy", {30'd0, ramstate}, {30'd0, BUSY});
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("drop_free", {30'd0, ramstate}, {30'd0, FREE});
    txn("rd08", 1'b0, 32'h08, 32'd0, 1'b1, 32'd0);

    // Write held past ACCESS restarts; second ACCESS commits the newer data
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 32'h30, (i < 3) ? 32'h1 : 32'h2);
      chk($sformatf("held_st%0d", i), {30'd0, ramstate},
          (i == 2 || i == 5) ? {30'd0, ACCESS} : {30'd0, BUSY});
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    txn("rd30", 1'b0, 32'h30, 32'd0, 1'b1, 32'h2);

    // Reset mid-read clears memory and restarts latency
    txn("wr00", 1'b1, 32'h0, 32'h12345678, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 32'd0);
    chk("rr_c0", {30'd0, ramstate}, {30'd0, BUSY});
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    chk("rr_in_rst", {30'd0, ramstate}, {30'd0, BUSY});
    chk("rr_load_rst", ramload, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("rr_rel0", {30'd0, ramstate}, {30'd0, BUSY});
    drive(1'b1, 1'b0, 32'h0, 32'd0);
    chk("rr_rel1", {30'd0, ramstate}, {30'd0, BUSY});
    drive(1'b1, 1'b0, 32'h0, 32'd0);
    chk("rr_rel2", {30'd0, ramstate}, {30'd0, ACCESS});
    chk("rr_load", ramload, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    txn("rd40_clr", 1'b0, 32'h40, 32'd0, 1'b1, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning access latency in cycles (legal range 1..15).
REQ-002 SHALL have parameter AW, default 10, meaning word-address width (memory holds 2^AW 32-bit words).
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ramREN  input  1  read request, level-held by the controller until ACCESS.
REQ-006 SHALL have port ramWEN  input  1  write request, level-held until ACCESS.
REQ-007 SHALL have port ramaddr  input  32  byte address; word index = ramaddr[AW+1:2].
REQ-008 SHALL have port ramstore  input  32  write data.
REQ-009 SHALL have port ramload  output  32  read data.
REQ-010 SHALL have port ramstate  output  2  status, encoded FREE=0, BUSY=1, ACCESS=2, ERROR=3 (cpu_types_pkg ramstate_t).

Function
REQ-011 SHALL classify each cycle combinationally: idle (REN=0, WEN=0), error (REN=1 and WEN=1, ramaddr[1:0]!=0, or ramaddr[31:AW+2]!=0), else valid request.
REQ-012 SHALL drive ramstate=FREE in idle cycles and ramstate=ERROR in error cycles, with no memory update and the latency counter cleared at the next edge.
REQ-013 SHALL keep a registered copy of the last valid request (type, address) and a 4-bit counter cnt.
REQ-014 SHALL treat a valid request as new when the previous cycle was idle/error/ACCESS or when type or address differ from the registered copy; a new request loads cnt=1 at the edge ending that cycle.
REQ-015 SHALL drive ramstate=BUSY while the current valid request has cnt<LAT (including its first cycle, cnt treated as 0), incrementing cnt each cycle.
REQ-016 SHALL drive ramstate=ACCESS for exactly one cycle, the cycle where cnt==LAT; for a request first presented in cycle t, ACCESS occurs in cycle t+LAT.
REQ-017 SHALL, in the ACCESS cycle of a read, present mem[word index] on ramload combinationally from the array; ramload SHALL hold its last ACCESS value in all other cycles.
REQ-018 SHALL commit ramstore to mem[word index] at the rising edge ending the ACCESS cycle of a write; no other cycle writes the array.
REQ-019 SHALL treat a request still held in the cycle after ACCESS as a new transaction (BUSY again, full LAT restart).
REQ-020 SHALL abort silently when the request drops or changes during BUSY: no memory effect; a changed request restarts counting per REQ-014.
REQ-021 SHALL never write memory while ramstate is BUSY, FREE or ERROR.
REQ-022 SHALL implement the state machine IDLE -> COUNT -> ACCESS -> (IDLE or COUNT), with COUNT -> COUNT on change and any state -> IDLE on idle/error input.

Reset
REQ-023 SHALL, while nRST=0, force state IDLE, cnt=0, registered request cleared, ramload=0, and every memory word to 0.
REQ-024 SHALL drive ramstate from inputs per REQ-012/015 during reset (BUSY for a held valid request), with no ACCESS and no write possible.
REQ-025 SHALL, on reset assertion mid-transaction, discard the transaction; after release a still-held request restarts with full latency.

Verification
REQ-026 Write 0xDEADBEEF to 0x40, LAT=2, held from cycle 0 -> ramstate BUSY, BUSY, ACCESS in cycles 0-2; subsequent read of 0x40 -> ramload=0xDEADBEEF in its ACCESS cycle.
REQ-027 REN=1 and WEN=1 at 0x10 -> ramstate=ERROR every cycle; later read of 0x10 returns 0x00000000.
REQ-028 Read 0x20 with address changed to 0x24 in cycle 1 -> ACCESS at cycle 3 (not 2), data from 0x24.
REQ-029 Write to 0x08 dropped after one BUSY cycle -> FREE next cycle; read of 0x08 returns 0.
REQ-030 Write held through ACCESS into the next cycle -> BUSY restarts, second ACCESS LAT cycles later, final value equals ramstore.
REQ-031 nRST pulsed low during BUSY of a read to 0x0 after writing 0x12345678 -> memory cleared; read after release returns 0 with full LAT latency.
